// File: rtl/spi_mem_responder_if.sv
// Serial memory link between the SoC memory controller (master) and the
// emulated memory device (slave).
interface spi_mem_responder_if;
  logic sclk;
  logic ce_n;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic active;

  modport master (output sclk, ce_n, mosi, input miso, miso_oe, active);
  modport slave  (input sclk, ce_n, mosi, output miso, miso_oe, active);
endinterface

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory target: READ / FAST READ / WRITE / READ ID over a small
// byte array, with all pad inputs oversampled on clk.
module spi_mem_responder #(
  parameter int unsigned AW   = 8,
  parameter logic [7:0]  MFID = 8'h0D,
  parameter logic [7:0]  KGD  = 8'h5D
) (
  input logic clk,
  input logic rst_n,
  spi_mem_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_ID, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {OP_RD, OP_FAST, OP_WR} op_t;

  state_t state, state_nxt;
  op_t    op, op_nxt;

  logic [1:0]    sclk_s, ce_s, mosi_s;
  logic          sclk_q;
  logic          sclk_r, ce_hi, mosi_r, rise, fall;
  logic [4:0]    bit_cnt;
  logic [2:0]    out_cnt;
  logic [6:0]    in_sr;
  logic [7:0]    out_sr;
  logic [AW-1:0] ptr;
  logic [1:0]    id_idx;
  logic          miso_q;
  logic [7:0]    cmd_byte, id_byte, src_byte, cur_byte;
  logic          oe, wr_en, rd_byte_done;

  logic [7:0] mem [2**AW];

  assign sclk_r = sclk_s[1];
  assign ce_hi  = ce_s[1];
  assign mosi_r = mosi_s[1];
  assign rise   = sclk_r & ~sclk_q;
  assign fall   = ~sclk_r & sclk_q;

  assign cmd_byte = {in_sr, mosi_r};
  assign oe       = (state == S_RDATA) || (state == S_ID);

  always_comb begin
    case (id_idx)
      2'd0:    id_byte = MFID;
      2'd1:    id_byte = KGD;
      default: id_byte = 8'hFF;
    endcase
  end

  // The first bit of each outgoing byte is taken straight from the source,
  // so the pointer only has to be valid by the first falling edge.
  assign src_byte = (state == S_ID) ? id_byte : mem[ptr];
  assign cur_byte = (out_cnt == 3'd0) ? src_byte : out_sr;

  assign wr_en        = rise && !ce_hi && (state == S_WDATA) && (bit_cnt == 5'd7);
  assign rd_byte_done = fall && !ce_hi && (state == S_RDATA) && (out_cnt == 3'd7);

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    case (state)
      S_IDLE: if (!ce_hi) state_nxt = S_CMD;
      S_CMD: if (rise && bit_cnt == 5'd7) begin
        case (cmd_byte)
          8'h03: begin state_nxt = S_ADDR; op_nxt = OP_RD;   end
          8'h0B: begin state_nxt = S_ADDR; op_nxt = OP_FAST; end
          8'h02: begin state_nxt = S_ADDR; op_nxt = OP_WR;   end
          8'h9F: state_nxt = S_ID;
          default: state_nxt = S_IGNORE;
        endcase
      end
      S_ADDR: if (rise && bit_cnt == 5'd23) begin
        case (op)
          OP_RD:   state_nxt = S_RDATA;
          OP_FAST: state_nxt = S_DUMMY;
          default: state_nxt = S_WDATA;
        endcase
      end
      S_DUMMY: if (rise && bit_cnt == 5'd7) state_nxt = S_RDATA;
      default: state_nxt = state;
    endcase
    // Deselect overrides everything, including a byte completing this cycle.
    if (ce_hi) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s  <= 2'b00;
      ce_s    <= 2'b11;
      mosi_s  <= 2'b00;
      sclk_q  <= 1'b0;
      state   <= S_IDLE;
      op      <= OP_RD;
      bit_cnt <= '0;
      out_cnt <= '0;
      in_sr   <= '0;
      out_sr  <= '0;
      ptr     <= '0;
      id_idx  <= '0;
      miso_q  <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], bus.sclk};
      ce_s   <= {ce_s[0], bus.ce_n};
      mosi_s <= {mosi_s[0], bus.mosi};
      sclk_q <= sclk_r;
      state  <= state_nxt;
      op     <= op_nxt;

      if (state_nxt != state) begin
        bit_cnt <= '0;
        out_cnt <= '0;
        id_idx  <= '0;
        miso_q  <= 1'b0;
      end else if (rise) begin
        bit_cnt <= (state == S_WDATA && bit_cnt == 5'd7) ? '0 : bit_cnt + 5'd1;
      end

      if (rise && !ce_hi) in_sr <= {in_sr[5:0], mosi_r};

      if (rise && !ce_hi && state == S_ADDR) ptr <= {ptr[AW-2:0], mosi_r};
      else if (wr_en || rd_byte_done)        ptr <= ptr + AW'(1);

      if (fall && !ce_hi && oe) begin
        miso_q  <= cur_byte[7];
        out_sr  <= {cur_byte[6:0], 1'b0};
        out_cnt <= out_cnt + 3'd1;
        if (state == S_ID && out_cnt == 3'd7 && id_idx != 2'd2) id_idx <= id_idx + 2'd1;
      end
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= {in_sr, mosi_r};
  end

  assign bus.miso    = miso_q & oe;
  assign bus.miso_oe = oe;
  assign bus.active  = ~ce_hi;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: drives mode-0 transactions and checks
// returned bytes, output-enable behaviour and reset against fixed values.
module tb_spi_mem_responder;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  spi_mem_responder_if bus ();

  spi_mem_responder #(.AW(8), .MFID(8'h0D), .KGD(8'h5D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: mosi set while sclk low, miso sampled just before the rise.
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx, output int oe_cnt);
    rx = 8'h00;
    oe_cnt = 0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      wait_clk(HALF);
      rx = {rx[6:0], bus.miso};
      if (bus.miso_oe) oe_cnt++;
      bus.sclk = 1'b1;
      wait_clk(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic begin_txn();
    bus.ce_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic end_txn();
    wait_clk(HALF);
    bus.ce_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] rx;
    int oc;
    xfer(b, 8, rx, oc);
  endtask

  task automatic cmd_addr(input logic [7:0] cmd, input logic [23:0] addr);
    begin_txn();
    send(cmd);
    send(addr[23:16]);
    send(addr[15:8]);
    send(addr[7:0]);
  endtask

  task automatic write2(input logic [23:0] addr, input logic [7:0] d0, input logic [7:0] d1);
    cmd_addr(8'h02, addr);
    send(d0);
    send(d1);
    end_txn();
  endtask

  task automatic read_chk(input string tag, input logic [23:0] addr, input logic [7:0] exp);
    logic [7:0] rx;
    int oc;
    cmd_addr(8'h03, addr);
    xfer(8'h00, 8, rx, oc);
    chk(tag, rx, exp);
    end_txn();
  endtask

  initial begin
    logic [7:0] rx;
    int oc;

    rst_n    = 1'b0;
    bus.ce_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    wait_clk(3);
    chk("rst_oe", bus.miso_oe, 1'b0);
    chk("rst_miso", bus.miso, 1'b0);
    chk("rst_active", bus.active, 1'b0);
    rst_n = 1'b1;
    wait_clk(5);
    chk("idle_active", bus.active, 1'b0);

    // write then two-byte read
    write2(24'h000010, 8'hA5, 8'h3C);
    cmd_addr(8'h03, 24'h000010);
    chk("rd_active", bus.active, 1'b1);
    xfer(8'h00, 8, rx, oc);
    chk("rd_b0", rx, 8'hA5);
    chk("rd_b0_oe", oc, 8);
    xfer(8'h00, 8, rx, oc);
    chk("rd_b1", rx, 8'h3C);
    end_txn();
    chk("rd_end_oe", bus.miso_oe, 1'b0);

    // fast read with dummy byte
    cmd_addr(8'h0B, 24'h000010);
    xfer(8'hFF, 8, rx, oc);
    chk("fast_dummy_oe", oc, 0);
    xfer(8'h00, 8, rx, oc);
    chk("fast_b0", rx, 8'hA5);
    xfer(8'h00, 8, rx, oc);
    chk("fast_b1", rx, 8'h3C);
    end_txn();

    // pointer wrap on write and read
    write2(24'h0000FF, 8'h11, 8'h22);
    read_chk("wrap_wr_0", 24'h000000, 8'h22);
    cmd_addr(8'h03, 24'h0000FF);
    xfer(8'h00, 8, rx, oc);
    chk("wrap_rd_ff", rx, 8'h11);
    xfer(8'h00, 8, rx, oc);
    chk("wrap_rd_00", rx, 8'h22);
    end_txn();

    // read id
    begin_txn();
    send(8'h9F);
    xfer(8'h00, 8, rx, oc); chk("id0", rx, 8'h0D); chk("id0_oe", oc, 8);
    xfer(8'h00, 8, rx, oc); chk("id1", rx, 8'h5D); chk("id1_oe", oc, 8);
    xfer(8'h00, 8, rx, oc); chk("id2", rx, 8'hFF); chk("id2_oe", oc, 8);
    xfer(8'h00, 8, rx, oc); chk("id3", rx, 8'hFF); chk("id3_oe", oc, 8);
    end_txn();

    // partial write byte is discarded
    write2(24'h000020, 8'h5A, 8'h77);
    cmd_addr(8'h02, 24'h000020);
    xfer(8'hF0, 4, rx, oc);
    end_txn();
    read_chk("partial_wr", 24'h000020, 8'h5A);
    read_chk("recover_rd", 24'h000010, 8'hA5);

    // deselect on the same cycle as the 8th rising edge wins
    write2(24'h000030, 8'hC3, 8'h00);
    cmd_addr(8'h02, 24'h000030);
    xfer(8'h96, 7, rx, oc);
    bus.mosi = 1'b0;
    wait_clk(HALF);
    bus.sclk = 1'b1;
    bus.ce_n = 1'b1;
    wait_clk(HALF);
    bus.sclk = 1'b0;
    wait_clk(10);
    read_chk("ce_race", 24'h000030, 8'hC3);

    // unknown command never drives
    begin_txn();
    xfer(8'hEB, 8, rx, oc);
    chk("ign_cmd_oe", oc, 0);
    xfer(8'h00, 8, rx, oc);
    chk("ign_oe", oc, 0);
    chk("ign_miso", rx, 8'h00);
    end_txn();

    // async reset in the middle of a read
    cmd_addr(8'h03, 24'h000010);
    xfer(8'h00, 8, rx, oc);
    chk("prerst_b0", rx, 8'hA5);
    xfer(8'h00, 3, rx, oc);
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", bus.miso_oe, 1'b0);
    chk("midrst_miso", bus.miso, 1'b0);
    chk("midrst_active", bus.active, 1'b0);
    bus.ce_n = 1'b1;
    bus.sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    read_chk("postrst_rd", 24'h000011, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
